pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Generates per-stage pause and flush signals, including the EXE stage's pause input.
- Detects load-use hazards and sequences multi-cycle mul/div occupancy of the EXE ALU.
- Resolves taken-branch flushes and produces forwarding selects for the EXE operand muxes.
- Sits beside the datapath; it is purely control and holds no datapath registers except its counters.

Parameters:
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..3).
MUL_CYCLES, 4, EXE occupancy of a multiply, in cycles.
DIV_CYCLES, 32, EXE occupancy of a divide, in cycles.
CNT_W, 6, width of the occupancy down-counter (must hold DIV_CYCLES).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
i_PCTL_idRs  in  5  ID-stage source register rs.
i_PCTL_idRt  in  5  ID-stage source register rt.
i_PCTL_idUseRs  in  1  ID instruction reads rs.
i_PCTL_idUseRt  in  1  ID instruction reads rt.
i_PCTL_exeWRA  in  5  EXE destination register.
i_PCTL_exeRegWe  in  1  EXE instruction writes a register.
i_PCTL_exeLoad  in  1  EXE instruction is a load.
i_PCTL_memWRA  in  5  MEM destination register.
i_PCTL_memRegWe  in  1  MEM instruction writes a register.
i_PCTL_mdStart  in  1  EXE holds a mul/div; valid one cycle.
i_PCTL_mdDiv  in  1  1 = divide, 0 = multiply; qualified by mdStart.
i_PCTL_brTaken  in  1  EXE branch unit clear (taken branch or jump).
o_PCTL_ifPause  out  1  hold PC/IF register.
o_PCTL_idPause  out  1  hold ID register.
o_PCTL_exePause  out  1  hold EXE register.
o_PCTL_idBubble  out  1  load NOP into EXE next edge.
o_PCTL_ifFlush  out  1  squash IF instruction.
o_PCTL_idFlush  out  1  squash ID instruction.
o_PCTL_fwdA  out  2  operand A select: 0 regfile, 1 MEM-stage aluOut, 2 WB data.
o_PCTL_fwdB  out  2  operand B select, same encoding.
o_PCTL_mdDone  out  1  one-cycle pulse on the last mul/div cycle.
o_PCTL_stallCnt  out  32  count of cycles with ifPause=1; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, rst=1): state RUN, counter 0, stallCnt 0, all pause/flush/bubble/mdDone 0, fwd 0.
- States: RUN, LDSTALL, MDBUSY.
- Load-use hazard (hz), all terms required:
  - exeLoad & exeRegWe & exeWRA≠0;
  - exeWRA matches rs with idUseRs, or matches rt with idUseRt.
- RUN, priority order:
  - brTaken: ifFlush=idFlush=1 same cycle; hz ignored; no stall. Remain RUN.
  - mdStart: counter ← (mdDiv ? DIV_CYCLES : MUL_CYCLES)−1; go MDBUSY. From the same cycle, ifPause, idPause and exePause are asserted combinationally.
  - hz: ifPause=idPause=1, idBubble=1. If LOAD_LAT>1, counter ← LOAD_LAT−1 and go LDSTALL; else remain RUN.
- LDSTALL: ifPause=idPause=idBubble=1. Counter decrements each cycle; at counter=1 return to RUN.
- MDBUSY: ifPause=idPause=exePause=1. Counter decrements; at counter=0, mdDone=1, pauses drop the same cycle, go RUN. brTaken in MDBUSY is impossible and is ignored.
- Total pause cycles on mdStart equal the occupancy: 4 for a multiply, 32 for a divide.
- Flush vs pause: when a flush and a pause would coincide, the flush wins for IF/ID.
- Forwarding (combinational, per operand):
  - 1 if memRegWe & memWRA≠0 & memWRA==src;
  - else 2 if the WB write matches, using the registered MEM WRA/regWe delayed one cycle inside this block;
  - else 0.
  - Register 0 never forwards.
- stallCnt increments on every cycle with ifPause=1 and saturates at max.
- rst asserted mid-MDBUSY or mid-LDSTALL aborts immediately to reset values; no mdDone pulse.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (RUN=0, LDSTALL=1, MDBUSY=2);
  - FWD_RF=0, FWD_MEM=1, FWD_WB=2;
  - REG_ZERO=5'd0.
- One natural sub-module: hazard_fwd_unit, the combinational hz detection plus fwdA/fwdB logic. The FSM, counters and stallCnt stay in pipe_ctrl.

Test Plan:
- Load-use: exeLoad=1, exeRegWe=1, exeWRA=5, idRs=5, idUseRs=1 → exactly 1 cycle of ifPause=idPause=idBubble=1; stallCnt=1.
- Load to $0: exeWRA=0, idRs=0 → no pause, no bubble.
- Divide: mdStart=1, mdDiv=1 → exePause high for 32 cycles; mdDone pulses on cycle 32; stallCnt=32. Multiply: 4 cycles.
- Branch plus hazard in the same cycle: brTaken=1 with a hz condition → ifFlush=idFlush=1, no pause, stallCnt unchanged.
- Forwarding: memWRA=7, memRegWe=1, idRs=7 → fwdA=1. Next cycle with MEM idle → fwdA=2. srcs=0 → fwdA=0.
- Reset mid-divide: rst at busy cycle 10 → all outputs 0 asynchronously, no mdDone; after release, state RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline control block: FSM states,
// forwarding-select codes and the forwarding priority helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MDBUSY  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Forwarding select for one source operand. MEM is the youngest producer,
  // so it beats WB. Register 0 is hard-wired and never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_wra,
    input logic       mem_we,
    input logic [4:0] wb_wra,
    input logic       wb_we
  );
    logic [1:0] sel;
    if (mem_we && (mem_wra != REG_ZERO) && (mem_wra == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_wra != REG_ZERO) && (wb_wra == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and EXE operand forwarding selects.
module hazard_fwd_unit
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] exe_wra,
  input  logic       exe_reg_we,
  input  logic       exe_load,
  input  logic [4:0] mem_wra,
  input  logic       mem_reg_we,
  input  logic [4:0] wb_wra,
  input  logic       wb_reg_we,
  output logic       hz,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic load_dst_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Hazard only when a real load in EXE targets a register the ID instruction reads.
  always_comb begin
    load_dst_s = exe_load && exe_reg_we && (exe_wra != REG_ZERO);
    rs_hit_s   = id_use_rs && (exe_wra == id_rs);
    rt_hit_s   = id_use_rt && (exe_wra == id_rt);
    hz         = load_dst_s && (rs_hit_s || rt_hit_s);
  end

  // Per-operand forwarding priority: MEM, then WB, else register file.
  always_comb begin
    fwd_a = fwd_sel(id_rs, mem_wra, mem_reg_we, wb_wra, wb_reg_we);
    fwd_b = fwd_sel(id_rt, mem_wra, mem_reg_we, wb_wra, wb_reg_we);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, mul/div EXE occupancy,
// taken-branch flushes, forwarding selects and a saturating stall counter.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_LAT   = 1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_PCTL_idRs,
  input  logic [4:0]  i_PCTL_idRt,
  input  logic        i_PCTL_idUseRs,
  input  logic        i_PCTL_idUseRt,
  input  logic [4:0]  i_PCTL_exeWRA,
  input  logic        i_PCTL_exeRegWe,
  input  logic        i_PCTL_exeLoad,
  input  logic [4:0]  i_PCTL_memWRA,
  input  logic        i_PCTL_memRegWe,
  input  logic        i_PCTL_mdStart,
  input  logic        i_PCTL_mdDiv,
  input  logic        i_PCTL_brTaken,
  output logic        o_PCTL_ifPause,
  output logic        o_PCTL_idPause,
  output logic        o_PCTL_exePause,
  output logic        o_PCTL_idBubble,
  output logic        o_PCTL_ifFlush,
  output logic        o_PCTL_idFlush,
  output logic [1:0]  o_PCTL_fwdA,
  output logic [1:0]  o_PCTL_fwdB,
  output logic        o_PCTL_mdDone,
  output logic [31:0] o_PCTL_stallCnt
);

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [4:0]         wb_wra_r;
  logic               wb_we_r;
  logic [31:0]        stall_cnt_r;
  logic               hz_s;
  logic [1:0]         fwd_a_s, fwd_b_s;
  logic               if_pause_s, id_pause_s, exe_pause_s, bubble_s;
  logic               flush_s, md_done_s;

  hazard_fwd_unit u_hfu (
    .id_rs      (i_PCTL_idRs),
    .id_rt      (i_PCTL_idRt),
    .id_use_rs  (i_PCTL_idUseRs),
    .id_use_rt  (i_PCTL_idUseRt),
    .exe_wra    (i_PCTL_exeWRA),
    .exe_reg_we (i_PCTL_exeRegWe),
    .exe_load   (i_PCTL_exeLoad),
    .mem_wra    (i_PCTL_memWRA),
    .mem_reg_we (i_PCTL_memRegWe),
    .wb_wra     (wb_wra_r),
    .wb_reg_we  (wb_we_r),
    .hz         (hz_s),
    .fwd_a      (fwd_a_s),
    .fwd_b      (fwd_b_s)
  );

  // Next-state, counter and raw control decode.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    if_pause_s  = 1'b0;
    id_pause_s  = 1'b0;
    exe_pause_s = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    md_done_s   = 1'b0;
    unique case (state_r)
      ST_RUN: begin
        if (i_PCTL_brTaken) begin
          flush_s = 1'b1;
        end else if (i_PCTL_mdStart) begin
          cnt_n       = i_PCTL_mdDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          state_n     = ST_MDBUSY;
          if_pause_s  = 1'b1;
          id_pause_s  = 1'b1;
          exe_pause_s = 1'b1;
        end else if (hz_s) begin
          if_pause_s = 1'b1;
          id_pause_s = 1'b1;
          bubble_s   = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_n   = CNT_W'(LOAD_LAT - 1);
            state_n = ST_LDSTALL;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (i_PCTL_brTaken) begin
          // Flush takes precedence over the remaining bubble cycles.
          flush_s = 1'b1;
          cnt_n   = '0;
          state_n = ST_RUN;
        end else begin
          if_pause_s = 1'b1;
          id_pause_s = 1'b1;
          bubble_s   = 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = ST_RUN;
          end else begin
            cnt_n = cnt_r - CNT_W'(1);
          end
        end
      end
      ST_MDBUSY: begin
        if (cnt_r == '0) begin
          md_done_s = 1'b1;
          state_n   = ST_RUN;
        end else begin
          if_pause_s  = 1'b1;
          id_pause_s  = 1'b1;
          exe_pause_s = 1'b1;
          cnt_n       = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Output gating: reset forces every control output low immediately.
  always_comb begin
    if (rst) begin
      o_PCTL_ifPause  = 1'b0;
      o_PCTL_idPause  = 1'b0;
      o_PCTL_exePause = 1'b0;
      o_PCTL_idBubble = 1'b0;
      o_PCTL_ifFlush  = 1'b0;
      o_PCTL_idFlush  = 1'b0;
      o_PCTL_mdDone   = 1'b0;
      o_PCTL_fwdA     = FWD_RF;
      o_PCTL_fwdB     = FWD_RF;
    end else begin
      o_PCTL_ifPause  = if_pause_s;
      o_PCTL_idPause  = id_pause_s;
      o_PCTL_exePause = exe_pause_s;
      o_PCTL_idBubble = bubble_s;
      o_PCTL_ifFlush  = flush_s;
      o_PCTL_idFlush  = flush_s;
      o_PCTL_mdDone   = md_done_s;
      o_PCTL_fwdA     = fwd_a_s;
      o_PCTL_fwdB     = fwd_b_s;
    end
  end

  // State, occupancy counter and WB-stage shadow of the MEM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      cnt_r    <= '0;
      wb_wra_r <= 5'd0;
      wb_we_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      wb_wra_r <= i_PCTL_memWRA;
      wb_we_r  <= i_PCTL_memRegWe;
    end
  end

  // Saturating count of cycles in which fetch is paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (o_PCTL_ifPause && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_PCTL_stallCnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default parameters).
`timescale 1ns/1ps
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, exe_wra, mem_wra;
  logic        use_rs, use_rt, exe_we, exe_load, mem_we;
  logic        md_start, md_div, br_taken;
  logic        if_pause, id_pause, exe_pause, id_bubble, if_flush, id_flush, md_done;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_PCTL_idRs     (id_rs),
    .i_PCTL_idRt     (id_rt),
    .i_PCTL_idUseRs  (use_rs),
    .i_PCTL_idUseRt  (use_rt),
    .i_PCTL_exeWRA   (exe_wra),
    .i_PCTL_exeRegWe (exe_we),
    .i_PCTL_exeLoad  (exe_load),
    .i_PCTL_memWRA   (mem_wra),
    .i_PCTL_memRegWe (mem_we),
    .i_PCTL_mdStart  (md_start),
    .i_PCTL_mdDiv    (md_div),
    .i_PCTL_brTaken  (br_taken),
    .o_PCTL_ifPause  (if_pause),
    .o_PCTL_idPause  (id_pause),
    .o_PCTL_exePause (exe_pause),
    .o_PCTL_idBubble (id_bubble),
    .o_PCTL_ifFlush  (if_flush),
    .o_PCTL_idFlush  (id_flush),
    .o_PCTL_fwdA     (fwd_a),
    .o_PCTL_fwdB     (fwd_b),
    .o_PCTL_mdDone   (md_done),
    .o_PCTL_stallCnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    exe_wra = 5'd0; exe_we = 1'b0; exe_load = 1'b0;
    mem_wra = 5'd0; mem_we = 1'b0;
    md_start = 1'b0; md_div = 1'b0; br_taken = 1'b0;
  endtask

  // Issue a mul/div and count paused cycles (start cycle included) until mdDone.
  task automatic run_md(input logic div, input string tag, input int exp_pause,
                        input logic [31:0] exp_stall);
    int  pcnt = 0;
    bit  done = 1'b0;
    md_start = 1'b1;
    md_div   = div;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exe_pause) pcnt++;
      if (md_done) begin
        done = 1'b1;
        check({tag, "_ifpause_at_done"}, {31'd0, if_pause}, 32'd0);
      end
      tick();
      md_start = 1'b0;
      if (done) break;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_pause_cycles"}, pcnt, exp_pause);
    @(negedge clk);
    check({tag, "_done_single"}, {31'd0, md_done}, 32'd0);
    check({tag, "_stallcnt"}, stall_cnt, exp_stall);
  endtask

  initial begin
    int dones;
    int pauses;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ifpause", {31'd0, if_pause}, 32'd0);
    check("rst_exepause", {31'd0, exe_pause}, 32'd0);
    check("rst_stallcnt", stall_cnt, 32'd0);
    check("rst_fwda", {30'd0, fwd_a}, 32'd0);
    tick();
    rst = 1'b0;

    // Load-use on rs: single bubble cycle.
    exe_load = 1'b1; exe_we = 1'b1; exe_wra = 5'd5; id_rs = 5'd5; use_rs = 1'b1;
    @(negedge clk);
    check("lu_ifpause", {31'd0, if_pause}, 32'd1);
    check("lu_idpause", {31'd0, id_pause}, 32'd1);
    check("lu_bubble", {31'd0, id_bubble}, 32'd1);
    check("lu_exepause", {31'd0, exe_pause}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("lu_after_pause", {31'd0, if_pause}, 32'd0);
    check("lu_stallcnt", stall_cnt, 32'd1);
    tick();

    // Load to $0 never stalls.
    exe_load = 1'b1; exe_we = 1'b1; exe_wra = 5'd0; id_rs = 5'd0; use_rs = 1'b1;
    @(negedge clk);
    check("ld0_ifpause", {31'd0, if_pause}, 32'd0);
    check("ld0_bubble", {31'd0, id_bubble}, 32'd0);
    tick();

    // Hazard on rt only.
    exe_wra = 5'd9; id_rs = 5'd3; id_rt = 5'd9; use_rs = 1'b1; use_rt = 1'b1;
    @(negedge clk);
    check("lu_rt_bubble", {31'd0, id_bubble}, 32'd1);
    tick();
    // Match on rt but rt not read: no hazard.
    use_rt = 1'b0;
    @(negedge clk);
    check("lu_rt_unused", {31'd0, if_pause}, 32'd0);
    tick();
    idle_inputs();

    // Branch coinciding with a hazard: flush only.
    exe_load = 1'b1; exe_we = 1'b1; exe_wra = 5'd5; id_rs = 5'd5; use_rs = 1'b1;
    br_taken = 1'b1;
    @(negedge clk);
    check("br_ifflush", {31'd0, if_flush}, 32'd1);
    check("br_idflush", {31'd0, id_flush}, 32'd1);
    check("br_ifpause", {31'd0, if_pause}, 32'd0);
    check("br_bubble", {31'd0, id_bubble}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("br_stallcnt", stall_cnt, 32'd2);
    check("br_flush_drop", {31'd0, if_flush}, 32'd0);
    tick();

    // Multiply then divide occupancy.
    run_md(1'b0, "mul", 4, 32'd6);
    tick();
    run_md(1'b1, "div", 32, 32'd38);
    tick();

    // Forwarding from MEM, then WB, then register 0.
    mem_wra = 5'd7; mem_we = 1'b1; id_rs = 5'd7; id_rt = 5'd7;
    @(negedge clk);
    check("fwd_mem_a", {30'd0, fwd_a}, 32'd1);
    check("fwd_mem_b", {30'd0, fwd_b}, 32'd1);
    tick();
    mem_wra = 5'd0; mem_we = 1'b0;
    @(negedge clk);
    check("fwd_wb_a", {30'd0, fwd_a}, 32'd2);
    tick();
    mem_wra = 5'd0; mem_we = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    @(negedge clk);
    check("fwd_zero_a", {30'd0, fwd_a}, 32'd0);
    check("fwd_zero_b", {30'd0, fwd_b}, 32'd0);
    tick();
    // MEM beats WB when both match.
    mem_wra = 5'd4; mem_we = 1'b1; id_rs = 5'd4;
    tick();
    @(negedge clk);
    check("fwd_mem_over_wb", {30'd0, fwd_a}, 32'd1);
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a divide.
    md_start = 1'b1; md_div = 1'b1;
    tick();
    md_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("mid_busy_exepause", {31'd0, exe_pause}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_exepause", {31'd0, exe_pause}, 32'd0);
    check("rstmid_ifpause", {31'd0, if_pause}, 32'd0);
    check("rstmid_mddone", {31'd0, md_done}, 32'd0);
    check("rstmid_stallcnt", stall_cnt, 32'd0);
    tick();
    rst = 1'b0;
    dones  = 0;
    pauses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) dones++;
      if (exe_pause) pauses++;
      tick();
    end
    check("rstmid_no_done", dones, 0);
    check("rstmid_no_pause", pauses, 0);
    // Back in RUN: a fresh load-use stalls for exactly one cycle.
    exe_load = 1'b1; exe_we = 1'b1; exe_wra = 5'd6; id_rt = 5'd6; use_rt = 1'b1;
    @(negedge clk);
    check("post_rst_bubble", {31'd0, id_bubble}, 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("post_rst_stallcnt", stall_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
